// File: rtl/rob_nway.sv
// -----------------------------------------------------------------------------
// rob_nway : N-way superscalar reorder buffer
//
// Sits between dispatch/rename and retire. Up to N instructions enter at the
// tail each cycle, up to N out-of-order completions update entries, and up to
// N completed entries leave in program order at the head, carrying T/T_old so
// the retire stage can update the freelist and architectural map.
//
// Ports
//   clock_i, reset_i             clock, synchronous active-high reset
//   dispatch_*_i                 N dispatch slots (valid contiguous from slot 0)
//   free_slots_o                 ROB_SZ - count (registered occupancy only)
//   tail_idx_o                   entry index given to dispatch slot 0
//   complete_*_i                 N completion ports (higher port wins on clash)
//   retire_stall_i               retire stage cannot accept this cycle
//   retire_en_o, retire_*_o      contiguous in-order retire window
//   head_idx_o, count_o          head pointer and occupancy
//   squash_o                     a mispredicted branch retires this cycle
//
// Optional feature (macro ROB_STATS_EN): adds saturating 32-bit counters
//   stat_retired_o, stat_squash_o, stat_full_cycles_o.
// -----------------------------------------------------------------------------
module rob_nway #(
    parameter int ROB_SZ = 32,
    parameter int N      = 2,
    parameter int XLEN   = 32,
    parameter int PREG_W = 6,
    parameter int IDX_W  = $clog2(ROB_SZ)
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [N-1:0]        dispatch_en_i,
    input  logic [N*PREG_W-1:0] dispatch_t_i,
    input  logic [N*PREG_W-1:0] dispatch_t_old_i,
    input  logic [N*5-1:0]      dispatch_dest_i,
    input  logic [N*XLEN-1:0]   dispatch_npc_i,
    input  logic [N-1:0]        dispatch_halt_i,
    input  logic [N-1:0]        dispatch_wr_mem_i,
    output logic [IDX_W:0]      free_slots_o,
    output logic [IDX_W-1:0]    tail_idx_o,
    input  logic [N-1:0]        complete_en_i,
    input  logic [N*IDX_W-1:0]  complete_idx_i,
    input  logic [N*XLEN-1:0]   complete_result_i,
    input  logic [N-1:0]        complete_take_branch_i,
    input  logic [N-1:0]        complete_mispredict_i,
    input  logic                retire_stall_i,
    output logic [N-1:0]        retire_en_o,
    output logic [N*PREG_W-1:0] retire_t_o,
    output logic [N*PREG_W-1:0] retire_t_old_o,
    output logic [N*5-1:0]      retire_dest_o,
    output logic [N*XLEN-1:0]   retire_npc_o,
    output logic [N*XLEN-1:0]   retire_result_o,
    output logic [N-1:0]        retire_halt_o,
    output logic [N-1:0]        retire_wr_mem_o,
    output logic [N-1:0]        retire_take_branch_o,
    output logic [IDX_W-1:0]    head_idx_o,
    output logic [IDX_W:0]      count_o,
    output logic                squash_o
`ifdef ROB_STATS_EN
    ,
    output logic [31:0]         stat_retired_o,
    output logic [31:0]         stat_squash_o,
    output logic [31:0]         stat_full_cycles_o
`endif
);

    localparam int CNT_W = IDX_W + 1;

    // Per-entry status flags
    logic [ROB_SZ-1:0] valid_q, valid_d;
    logic [ROB_SZ-1:0] complete_q, complete_d;
    logic [ROB_SZ-1:0] mispred_q, mispred_d;
    logic [ROB_SZ-1:0] take_q, take_d;
    logic [ROB_SZ-1:0] halt_q, halt_d;
    logic [ROB_SZ-1:0] wr_mem_q, wr_mem_d;

    // Per-entry payload
    logic [PREG_W-1:0] t_q      [ROB_SZ];
    logic [PREG_W-1:0] t_d      [ROB_SZ];
    logic [PREG_W-1:0] t_old_q  [ROB_SZ];
    logic [PREG_W-1:0] t_old_d  [ROB_SZ];
    logic [4:0]        dest_q   [ROB_SZ];
    logic [4:0]        dest_d   [ROB_SZ];
    logic [XLEN-1:0]   npc_q    [ROB_SZ];
    logic [XLEN-1:0]   npc_d    [ROB_SZ];
    logic [XLEN-1:0]   result_q [ROB_SZ];
    logic [XLEN-1:0]   result_d [ROB_SZ];

    // Pointers and occupancy; full vs empty is decided by count, not pointers
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [IDX_W-1:0] ret_idx [N];
    logic [IDX_W-1:0] dsp_idx [N];
    logic [IDX_W-1:0] cmp_idx [N];
    logic [N-1:0]     retire_en;
    logic             squash;
    logic [CNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0] disp_cnt;
    logic [CNT_W-1:0] free_slots;
    logic             disp_ok;

    // Entry indices addressed by each retire slot, dispatch slot and completion port
    always_comb begin
        for (int k = 0; k < N; k++) begin
            ret_idx[k] = head_q + IDX_W'(k);
            dsp_idx[k] = tail_q + IDX_W'(k);
            cmp_idx[k] = complete_idx_i[k*IDX_W +: IDX_W];
        end
    end

    // In-order retire window: stops at the first not-ready entry, and right
    // after an entry that halts or mispredicts (that entry still retires)
    always_comb begin
        logic blocked;
        retire_en = '0;
        squash    = 1'b0;
        ret_cnt   = '0;
        blocked   = retire_stall_i;
        for (int k = 0; k < N; k++) begin
            if (!blocked && valid_q[ret_idx[k]] && complete_q[ret_idx[k]]) begin
                retire_en[k] = 1'b1;
                ret_cnt      = ret_cnt + CNT_W'(1);
                if (mispred_q[ret_idx[k]]) begin
                    squash  = 1'b1;
                    blocked = 1'b1;
                end else begin
                    blocked = halt_q[ret_idx[k]];
                end
            end else begin
                blocked = 1'b1;
            end
        end
    end

    // Retire payload for each window slot (qualified by retire_en_o downstream)
    always_comb begin
        retire_t_o           = '0;
        retire_t_old_o       = '0;
        retire_dest_o        = '0;
        retire_npc_o         = '0;
        retire_result_o      = '0;
        retire_halt_o        = '0;
        retire_wr_mem_o      = '0;
        retire_take_branch_o = '0;
        for (int k = 0; k < N; k++) begin
            retire_t_o[k*PREG_W +: PREG_W]     = t_q[ret_idx[k]];
            retire_t_old_o[k*PREG_W +: PREG_W] = t_old_q[ret_idx[k]];
            retire_dest_o[k*5 +: 5]            = dest_q[ret_idx[k]];
            retire_npc_o[k*XLEN +: XLEN]       = npc_q[ret_idx[k]];
            retire_result_o[k*XLEN +: XLEN]    = result_q[ret_idx[k]];
            retire_halt_o[k]                   = halt_q[ret_idx[k]];
            retire_wr_mem_o[k]                 = wr_mem_q[ret_idx[k]];
            retire_take_branch_o[k]            = take_q[ret_idx[k]];
        end
    end

    // Dispatch is all-or-nothing against the registered free count
    always_comb begin
        disp_cnt = '0;
        for (int k = 0; k < N; k++) begin
            disp_cnt = disp_cnt + CNT_W'(dispatch_en_i[k]);
        end
    end

    assign free_slots = CNT_W'(ROB_SZ) - count_q;
    assign disp_ok    = (disp_cnt <= free_slots) && !squash;

    // Next-state: completions, retire clears, dispatch writes, squash flush
    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q;
        mispred_d  = mispred_q;
        take_d     = take_q;
        halt_d     = halt_q;
        wr_mem_d   = wr_mem_q;
        t_d        = t_q;
        t_old_d    = t_old_q;
        dest_d     = dest_q;
        npc_d      = npc_q;
        result_d   = result_q;
        head_d     = head_q + ret_cnt[IDX_W-1:0];
        tail_d     = tail_q;
        count_d    = count_q - ret_cnt;
        if (squash) begin
            // Everything younger than the mispredict is wrong-path; drop it and
            // this cycle's dispatch/completions with it.
            valid_d = '0;
            tail_d  = head_q + ret_cnt[IDX_W-1:0];
            count_d = '0;
        end else begin
            // Ascending port order so the higher port wins a same-index clash
            for (int i = 0; i < N; i++) begin
                if (complete_en_i[i] && valid_q[cmp_idx[i]]) begin
                    complete_d[cmp_idx[i]] = 1'b1;
                    result_d[cmp_idx[i]]   = complete_result_i[i*XLEN +: XLEN];
                    take_d[cmp_idx[i]]     = complete_take_branch_i[i];
                    mispred_d[cmp_idx[i]]  = complete_mispredict_i[i];
                end else begin
                    // idle port or target not in flight: ignored
                end
            end
            for (int k = 0; k < N; k++) begin
                valid_d[ret_idx[k]] = retire_en[k] ? 1'b0 : valid_d[ret_idx[k]];
            end
            if (disp_ok) begin
                // Dispatch only lands in free entries, never on a retiring one
                for (int k = 0; k < N; k++) begin
                    if (dispatch_en_i[k]) begin
                        valid_d[dsp_idx[k]]    = 1'b1;
                        complete_d[dsp_idx[k]] = 1'b0;
                        mispred_d[dsp_idx[k]]  = 1'b0;
                        take_d[dsp_idx[k]]     = 1'b0;
                        halt_d[dsp_idx[k]]     = dispatch_halt_i[k];
                        wr_mem_d[dsp_idx[k]]   = dispatch_wr_mem_i[k];
                        t_d[dsp_idx[k]]        = dispatch_t_i[k*PREG_W +: PREG_W];
                        t_old_d[dsp_idx[k]]    = dispatch_t_old_i[k*PREG_W +: PREG_W];
                        dest_d[dsp_idx[k]]     = dispatch_dest_i[k*5 +: 5];
                        npc_d[dsp_idx[k]]      = dispatch_npc_i[k*XLEN +: XLEN];
                    end else begin
                        // slot unused this cycle
                    end
                end
                tail_d  = tail_q + disp_cnt[IDX_W-1:0];
                count_d = count_q + disp_cnt - ret_cnt;
            end else begin
                tail_d = tail_q;
            end
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            valid_q    <= '0;
            complete_q <= '0;
            mispred_q  <= '0;
            take_q     <= '0;
            halt_q     <= '0;
            wr_mem_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            complete_q <= complete_d;
            mispred_q  <= mispred_d;
            take_q     <= take_d;
            halt_q     <= halt_d;
            wr_mem_q   <= wr_mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Payload storage; contents are meaningless until an entry is valid
    always_ff @(posedge clock_i) begin
        t_q      <= t_d;
        t_old_q  <= t_old_d;
        dest_q   <= dest_d;
        npc_q    <= npc_d;
        result_q <= result_d;
    end

    assign retire_en_o  = retire_en;
    assign squash_o     = squash;
    assign free_slots_o = free_slots;
    assign tail_idx_o   = tail_q;
    assign head_idx_o   = head_q;
    assign count_o      = count_q;

`ifdef ROB_STATS_EN
    logic [31:0] stat_retired_q, stat_retired_d;
    logic [31:0] stat_squash_q, stat_squash_d;
    logic [31:0] stat_full_q, stat_full_d;
    logic [32:0] ret_sum;

    // Saturating statistics counters
    always_comb begin
        ret_sum        = {1'b0, stat_retired_q} + 33'(ret_cnt);
        stat_retired_d = ret_sum[32] ? 32'hFFFF_FFFF : ret_sum[31:0];
        if (squash && (stat_squash_q != 32'hFFFF_FFFF)) begin
            stat_squash_d = stat_squash_q + 32'd1;
        end else begin
            stat_squash_d = stat_squash_q;
        end
        if ((count_q == CNT_W'(ROB_SZ)) && (stat_full_q != 32'hFFFF_FFFF)) begin
            stat_full_d = stat_full_q + 32'd1;
        end else begin
            stat_full_d = stat_full_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stat_retired_q <= 32'd0;
            stat_squash_q  <= 32'd0;
            stat_full_q    <= 32'd0;
        end else begin
            stat_retired_q <= stat_retired_d;
            stat_squash_q  <= stat_squash_d;
            stat_full_q    <= stat_full_d;
        end
    end

    assign stat_retired_o     = stat_retired_q;
    assign stat_squash_o      = stat_squash_q;
    assign stat_full_cycles_o = stat_full_q;
`endif

endmodule

// File: tb/tb_rob_nway.sv
// -----------------------------------------------------------------------------
// tb_rob_nway : self-checking bench for rob_nway (N=2, ROB_SZ=32).
// Reference model keeps the in-flight instructions as a program-order queue.
// -----------------------------------------------------------------------------
module tb_rob_nway;
    localparam int N    = 2;
    localparam int SZ   = 32;
    localparam int XLEN = 32;
    localparam int PW   = 6;
    localparam int IW   = 5;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]      dispatch_en;
    logic [N*PW-1:0]   dispatch_t, dispatch_t_old;
    logic [N*5-1:0]    dispatch_dest;
    logic [N*XLEN-1:0] dispatch_npc;
    logic [N-1:0]      dispatch_halt, dispatch_wr_mem;
    logic [IW:0]       free_slots;
    logic [IW-1:0]     tail_idx;
    logic [N-1:0]      complete_en;
    logic [N*IW-1:0]   complete_idx;
    logic [N*XLEN-1:0] complete_result;
    logic [N-1:0]      complete_take_branch, complete_mispredict;
    logic              retire_stall;
    logic [N-1:0]      retire_en;
    logic [N*PW-1:0]   retire_t, retire_t_old;
    logic [N*5-1:0]    retire_dest;
    logic [N*XLEN-1:0] retire_npc, retire_result;
    logic [N-1:0]      retire_halt, retire_wr_mem, retire_take_branch;
    logic [IW-1:0]     head_idx;
    logic [IW:0]       count;
    logic              squash;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rob_nway #(.ROB_SZ(SZ), .N(N), .XLEN(XLEN), .PREG_W(PW)) dut (
        .clock_i(clk), .reset_i(rst),
        .dispatch_en_i(dispatch_en), .dispatch_t_i(dispatch_t), .dispatch_t_old_i(dispatch_t_old),
        .dispatch_dest_i(dispatch_dest), .dispatch_npc_i(dispatch_npc),
        .dispatch_halt_i(dispatch_halt), .dispatch_wr_mem_i(dispatch_wr_mem),
        .free_slots_o(free_slots), .tail_idx_o(tail_idx),
        .complete_en_i(complete_en), .complete_idx_i(complete_idx), .complete_result_i(complete_result),
        .complete_take_branch_i(complete_take_branch), .complete_mispredict_i(complete_mispredict),
        .retire_stall_i(retire_stall), .retire_en_o(retire_en),
        .retire_t_o(retire_t), .retire_t_old_o(retire_t_old), .retire_dest_o(retire_dest),
        .retire_npc_o(retire_npc), .retire_result_o(retire_result), .retire_halt_o(retire_halt),
        .retire_wr_mem_o(retire_wr_mem), .retire_take_branch_o(retire_take_branch),
        .head_idx_o(head_idx), .count_o(count), .squash_o(squash)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int              idx;
        logic [PW-1:0]   t, told;
        logic [4:0]      dest;
        logic [XLEN-1:0] npc, res;
        logic            halt, wrmem, done, take, misp;
    } ent_t;

    ent_t mq[$];
    int   m_head, m_tail;
    logic [N-1:0] exp_ren;
    logic exp_sq;
    int   exp_nret;

    function automatic void model_reset();
        mq.delete();
        m_head = 0;
        m_tail = 0;
    endfunction

    // Which of the oldest entries leave this cycle
    function automatic void model_expect();
        exp_ren  = '0;
        exp_sq   = 1'b0;
        exp_nret = 0;
        if (!retire_stall) begin
            for (int k = 0; k < N; k++) begin
                if (k >= mq.size()) break;
                if (!mq[k].done) break;
                exp_ren[k] = 1'b1;
                exp_nret++;
                if (mq[k].misp) begin
                    exp_sq = 1'b1;
                    break;
                end
                if (mq[k].halt) break;
            end
        end
    endfunction

    // Apply one clock edge of the current inputs to the model
    function automatic void model_commit();
        int size0 = mq.size();
        int k = 0;
        model_expect();
        if (exp_sq) begin
            m_head = (m_head + exp_nret) % SZ;
            mq.delete();
            m_tail = m_head;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (complete_en[i]) begin
                foreach (mq[j]) begin
                    if (mq[j].idx == int'(complete_idx[i*IW +: IW])) begin
                        mq[j].done = 1'b1;
                        mq[j].res  = complete_result[i*XLEN +: XLEN];
                        mq[j].take = complete_take_branch[i];
                        mq[j].misp = complete_mispredict[i];
                    end
                end
            end
        end
        repeat (exp_nret) void'(mq.pop_front());
        m_head = (m_head + exp_nret) % SZ;
        for (int j = 0; j < N; j++) k += int'(dispatch_en[j]);
        if (k <= SZ - size0) begin
            for (int j = 0; j < N; j++) begin
                if (dispatch_en[j]) begin
                    ent_t e;
                    e.idx = (m_tail + j) % SZ;
                    e.t = dispatch_t[j*PW +: PW];
                    e.told = dispatch_t_old[j*PW +: PW];
                    e.dest = dispatch_dest[j*5 +: 5];
                    e.npc = dispatch_npc[j*XLEN +: XLEN];
                    e.halt = dispatch_halt[j];
                    e.wrmem = dispatch_wr_mem[j];
                    e.done = 1'b0; e.take = 1'b0; e.misp = 1'b0; e.res = '0;
                    mq.push_back(e);
                end
            end
            m_tail = (m_tail + k) % SZ;
        end
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic clear_inputs();
        dispatch_en = '0; dispatch_t = '0; dispatch_t_old = '0; dispatch_dest = '0;
        dispatch_npc = '0; dispatch_halt = '0; dispatch_wr_mem = '0;
        complete_en = '0; complete_idx = '0; complete_result = '0;
        complete_take_branch = '0; complete_mispredict = '0; retire_stall = 1'b0;
    endtask

    task automatic set_dispatch(input int s, input bit h);
        dispatch_en[s] = 1'b1;
        dispatch_t[s*PW +: PW] = PW'($urandom);
        dispatch_t_old[s*PW +: PW] = PW'($urandom);
        dispatch_dest[s*5 +: 5] = 5'($urandom);
        dispatch_npc[s*XLEN +: XLEN] = $urandom;
        dispatch_halt[s] = h;
        dispatch_wr_mem[s] = 1'($urandom);
    endtask

    task automatic set_complete(input int p, input int idx, input bit misp);
        complete_en[p] = 1'b1;
        complete_idx[p*IW +: IW] = IW'(idx);
        complete_result[p*XLEN +: XLEN] = $urandom;
        complete_take_branch[p] = 1'($urandom);
        complete_mispredict[p] = misp;
    endtask

    task automatic advance();
        model_commit();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        if (count !== 6'd0)      begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++;
        if (free_slots !== 6'd32) begin errors++; $display("FAIL reset_free got %0d want 32", free_slots); end
        checks++;
        if (head_idx !== 5'd0 || tail_idx !== 5'd0) begin
            errors++; $display("FAIL reset_ptrs got head %0d tail %0d want 0 0", head_idx, tail_idx);
        end
        checks++;
        if (retire_en !== 2'b00 || squash !== 1'b0) begin
            errors++; $display("FAIL reset_retire got en %b squash %b want 00 0", retire_en, squash);
        end
        checks++;
        for (int c = 0; c < 3; c++) begin
            set_dispatch(0, 1'b0); set_dispatch(1, 1'b0); advance();
        end
        set_complete(0, 0, 1'b0); advance();
        do_reset();
        #1;
        if (count !== 6'd0 || free_slots !== 6'd32 || tail_idx !== 5'd0 || retire_en !== 2'b00) begin
            errors++;
            $display("FAIL midreset got count %0d free %0d tail %0d en %b want 0 32 0 00",
                     count, free_slots, tail_idx, retire_en);
        end
        checks++;
    endtask

    task automatic test_fill();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            set_dispatch(0, 1'b0); set_dispatch(1, 1'b0); advance();
        end
        #1;
        if (count !== 6'd32 || free_slots !== 6'd0 || tail_idx !== 5'd0) begin
            errors++; $display("FAIL fill_full got count %0d free %0d tail %0d want 32 0 0",
                               count, free_slots, tail_idx);
        end
        checks++;
        set_dispatch(0, 1'b0); set_dispatch(1, 1'b0); advance();
        #1;
        if (count !== 6'd32 || tail_idx !== 5'd0 || retire_en !== 2'b00) begin
            errors++; $display("FAIL fill_overflow got count %0d tail %0d en %b want 32 0 00",
                               count, tail_idx, retire_en);
        end
        checks++;
    endtask

    task automatic test_out_of_order();
        int order[4] = '{3, 1, 2, 0};
        do_reset();
        for (int c = 0; c < 2; c++) begin
            set_dispatch(0, 1'b0); set_dispatch(1, 1'b0); advance();
        end
        for (int i = 0; i < 4; i++) begin
            set_complete(0, order[i], 1'b0);
            #1;
            if (retire_en !== 2'b00) begin
                errors++; $display("FAIL ooo_wait%0d got %b want 00", i, retire_en);
            end
            checks++;
            advance();
        end
        #1;
        if (retire_en !== 2'b11 || head_idx !== 5'd0) begin
            errors++; $display("FAIL ooo_ret1 got en %b head %0d want 11 0", retire_en, head_idx);
        end
        checks++;
        advance(); #1;
        if (retire_en !== 2'b11 || head_idx !== 5'd2) begin
            errors++; $display("FAIL ooo_ret2 got en %b head %0d want 11 2", retire_en, head_idx);
        end
        checks++;
        advance(); #1;
        if (head_idx !== 5'd4 || count !== 6'd0 || retire_en !== 2'b00) begin
            errors++; $display("FAIL ooo_done got head %0d count %0d en %b want 4 0 00",
                               head_idx, count, retire_en);
        end
        checks++;
    endtask

    task automatic test_stall();
        do_reset();
        set_dispatch(0, 1'b0); set_dispatch(1, 1'b0); advance();
        set_complete(0, 0, 1'b0); set_complete(1, 1, 1'b0); advance();
        for (int c = 0; c < 3; c++) begin
            retire_stall = 1'b1;
            #1;
            if (retire_en !== 2'b00 || head_idx !== 5'd0) begin
                errors++; $display("FAIL stall%0d got en %b head %0d want 00 0", c, retire_en, head_idx);
            end
            checks++;
            advance();
        end
        #1;
        if (retire_en !== 2'b11) begin
            errors++; $display("FAIL stall_release got %b want 11", retire_en);
        end
        checks++;
        advance(); #1;
        if (head_idx !== 5'd2 || count !== 6'd0) begin
            errors++; $display("FAIL stall_after got head %0d count %0d want 2 0", head_idx, count);
        end
        checks++;
    endtask

    task automatic test_squash();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            set_dispatch(0, 1'b0); set_dispatch(1, 1'b0); advance();
        end
        set_complete(0, 0, 1'b0); set_complete(1, 1, 1'b0); advance();
        set_complete(0, 2, 1'b0); set_complete(1, 3, 1'b0); advance();
        set_complete(0, 4, 1'b0); advance();
        repeat (2) advance();
        #1;
        if (head_idx !== 5'd5 || count !== 6'd5) begin
            errors++; $display("FAIL squash_setup got head %0d count %0d want 5 5", head_idx, count);
        end
        checks++;
        set_complete(0, 5, 1'b1); set_complete(1, 6, 1'b0); advance();
        set_dispatch(0, 1'b0);
        #1;
        if (retire_en !== 2'b01 || squash !== 1'b1) begin
            errors++; $display("FAIL squash_retire got en %b squash %b want 01 1", retire_en, squash);
        end
        checks++;
        advance(); #1;
        if (count !== 6'd0 || tail_idx !== 5'd6 || head_idx !== 5'd6 || squash !== 1'b0) begin
            errors++; $display("FAIL squash_after got count %0d tail %0d head %0d squash %b want 0 6 6 0",
                               count, tail_idx, head_idx, squash);
        end
        checks++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 15; c++) begin
            set_dispatch(0, 1'b0); set_dispatch(1, 1'b0); advance();
        end
        for (int c = 0; c < 15; c++) begin
            set_complete(0, 2*c, 1'b0); set_complete(1, 2*c+1, 1'b0); advance();
        end
        repeat (2) advance();
        #1;
        if (head_idx !== 5'd30 || count !== 6'd0) begin
            errors++; $display("FAIL wrap_setup got head %0d count %0d want 30 0", head_idx, count);
        end
        checks++;
        for (int c = 0; c < 2; c++) begin
            set_dispatch(0, 1'b0); set_dispatch(1, 1'b0); advance();
        end
        #1;
        if (tail_idx !== 5'd2 || count !== 6'd4) begin
            errors++; $display("FAIL wrap_tail got tail %0d count %0d want 2 4", tail_idx, count);
        end
        checks++;
        set_complete(0, 30, 1'b0); set_complete(1, 31, 1'b0); advance();
        set_complete(0, 0, 1'b0); set_complete(1, 1, 1'b0);
        #1;
        if (retire_en !== 2'b11 || head_idx !== 5'd30 || retire_t !== {mq[1].t, mq[0].t}) begin
            errors++; $display("FAIL wrap_ret1 got en %b head %0d t %h want 11 30 %h",
                               retire_en, head_idx, retire_t, {mq[1].t, mq[0].t});
        end
        checks++;
        advance(); #1;
        if (retire_en !== 2'b11 || head_idx !== 5'd0 || retire_t !== {mq[1].t, mq[0].t}) begin
            errors++; $display("FAIL wrap_ret2 got en %b head %0d t %h want 11 0 %h",
                               retire_en, head_idx, retire_t, {mq[1].t, mq[0].t});
        end
        checks++;
        advance(); #1;
        if (count !== 6'd0 || head_idx !== 5'd2) begin
            errors++; $display("FAIL wrap_done got count %0d head %0d want 0 2", count, head_idx);
        end
        checks++;
    endtask

    task automatic test_halt();
        do_reset();
        set_dispatch(0, 1'b1); set_dispatch(1, 1'b0); advance();
        set_complete(0, 0, 1'b0); set_complete(1, 1, 1'b0); advance();
        #1;
        if (retire_en !== 2'b01 || retire_halt[0] !== 1'b1) begin
            errors++; $display("FAIL halt_slot0 got en %b halt %b want 01 1", retire_en, retire_halt[0]);
        end
        checks++;
        advance(); #1;
        if (retire_en !== 2'b01 || head_idx !== 5'd1) begin
            errors++; $display("FAIL halt_next got en %b head %0d want 01 1", retire_en, head_idx);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [83:0] got, want;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int nd = $urandom_range(0, N);
            for (int j = 0; j < nd; j++) set_dispatch(j, $urandom_range(0, 15) == 0);
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 9) < 6) begin
                    int idx;
                    if (mq.size() > 0 && $urandom_range(0, 9) < 8) idx = mq[$urandom_range(0, mq.size()-1)].idx;
                    else idx = $urandom_range(0, SZ-1);
                    set_complete(p, idx, $urandom_range(0, 29) == 0);
                end
            end
            retire_stall = ($urandom_range(0, 7) == 0);
            #1;
            model_expect();
            if (retire_en !== exp_ren || squash !== exp_sq) begin
                errors++; $display("FAIL rand_retire c%0d got en %b sq %b want %b %b",
                                   c, retire_en, squash, exp_ren, exp_sq);
            end
            checks++;
            if (count !== 6'(mq.size()) || free_slots !== 6'(SZ - mq.size()) ||
                head_idx !== 5'(m_head) || tail_idx !== 5'(m_tail)) begin
                errors++; $display("FAIL rand_state c%0d got cnt %0d free %0d head %0d tail %0d want %0d %0d %0d %0d",
                                   c, count, free_slots, head_idx, tail_idx,
                                   mq.size(), SZ - mq.size(), m_head, m_tail);
            end
            checks++;
            for (int k = 0; k < N; k++) begin
                if (exp_ren[k]) begin
                    got  = {retire_t[k*PW +: PW], retire_t_old[k*PW +: PW], retire_dest[k*5 +: 5],
                            retire_npc[k*XLEN +: XLEN], retire_result[k*XLEN +: XLEN],
                            retire_halt[k], retire_wr_mem[k], retire_take_branch[k]};
                    want = {mq[k].t, mq[k].told, mq[k].dest, mq[k].npc, mq[k].res,
                            mq[k].halt, mq[k].wrmem, mq[k].take};
                    if (got !== want) begin
                        errors++; $display("FAIL rand_fields c%0d slot%0d got %h want %h", c, k, got, want);
                    end
                    checks++;
                end
            end
            advance();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_fill();
        test_out_of_order();
        test_stall();
        test_squash();
        test_wrap();
        test_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_nway.md
Name: rob_nway

Overview:
- N-way superscalar reorder buffer: dispatches up to N instructions per cycle at the tail, accepts up to N out-of-order completions, retires up to N in-order at the head.
- Sits between dispatch/rename and the retire stage; supplies T/T_old for freelist/arch-map update.
- Generalises the single-issue ROB with parametrised depth/width, per-entry valid bits, and mispredict squash at retire.

Parameters:
- ROB_SZ, 32, entries; power of 2, >= 2*N.
- N, 2, dispatch/complete/retire width (1..4).
- XLEN, 32, data width.
- PREG_W, 6, physical tag width.
- IDX_W, $clog2(ROB_SZ), entry index width (derived).

Ports:
- clock in 1: system clock.
- reset in 1: reset, synchronous, active-high.
- dispatch_en in N: per-slot valid; must be contiguous from slot 0.
- dispatch_t / dispatch_t_old in N*PREG_W: new/old physical tags.
- dispatch_dest in N*5: arch dest register.
- dispatch_npc in N*XLEN: next PC.
- dispatch_halt, dispatch_wr_mem in N: flags.
- free_slots out IDX_W+1: empty entry count.
- tail_idx out IDX_W: index for dispatch slot 0; slot k gets (tail_idx+k) mod ROB_SZ.
- complete_en in N: completion strobes.
- complete_idx in N*IDX_W: target entries.
- complete_result in N*XLEN: results.
- complete_take_branch, complete_mispredict in N: branch outcome.
- retire_stall in 1: retire stage cannot accept.
- retire_en out N: contiguous retire valids.
- retire_t, retire_t_old, retire_dest, retire_npc, retire_result, retire_halt, retire_wr_mem, retire_take_branch out N*field: retiring entry fields.
- head_idx out IDX_W; count out IDX_W+1: occupancy.
- squash out 1: mispredicted branch retiring this cycle.

Behaviour:
- Reset: head_idx = tail_idx = count = 0; free_slots = ROB_SZ; all valid/complete bits 0; retire_en = 0; squash = 0.
- free_slots = ROB_SZ - count, registered occupancy only. Same-cycle retires do not free space.
- Dispatch is all-or-nothing. If popcount(dispatch_en) <= free_slots and no squash: write k entries (valid=1, complete=0, mispredict=0), tail += k mod ROB_SZ. Otherwise nothing is written and tail holds (assertion error).
- Completion: complete_en[i] with valid target sets complete=1 and latches result/take_branch/mispredict. Completion to an invalid entry is ignored. Duplicate idx in the same cycle: higher port wins (assertion flags it).
- Retire is combinational from registered state. retire_en[k] = !retire_stall && entries head..head+k all valid and complete && no halt or mispredict in slots <k. A halt or mispredict entry retires itself and blocks younger slots that cycle.
- Retire latency: an entry completing in cycle C can retire in C+1 at the earliest.
- On retire: clear valid, head += popcount(retire_en) mod ROB_SZ.
- squash = 1 when the retiring slot carries mispredict. Next cycle: all valid bits cleared, count = 0, tail = new head. Same-cycle dispatch and completions are dropped.
- count_next = count + dispatched - retired (0 after squash). count never exceeds ROB_SZ. Full: count = ROB_SZ, free_slots = 0. Empty: retire_en = 0.
- Indices wrap mod ROB_SZ; full/empty are distinguished by count, not by pointer equality.
- Reset mid-operation overrides everything; all in-flight entries are discarded.

Optional Feature:
- ROB_STATS_EN defined: adds outputs stat_retired (32), stat_squash (32), stat_full_cycles (32).
  - stat_retired accumulates popcount(retire_en).
  - stat_squash increments per squash.
  - stat_full_cycles increments each cycle count == ROB_SZ.
  - All cleared by reset; saturate at max.
- Undefined: these ports and counters do not exist; core behaviour is identical.

Test Plan:
- Reset, N=2: dispatch 2/cycle for 16 cycles with no completes -> count = 32, free_slots = 0, tail_idx = 0; a 17th dispatch is dropped and count stays 32.
- Fill 4 entries, complete idx 3,1,2,0 on successive cycles -> no retire until idx 0 completes; then retire_en = 2'b11 for two cycles, head_idx = 4.
- Retire_stall held 3 cycles with completed head -> retire_en = 0 and head fixed; release -> retires resume next cycle.
- Entry 5 completes with mispredict while entries 6..9 are valid -> entry 5 retires alone with squash = 1; next cycle count = 0, tail_idx = head_idx = 6; a dispatch in the squash cycle is ignored.
- Wrap: head = 30, dispatch 4, complete all -> retires idx 30,31 then 0,1; count returns to 0.
- Halt in slot 0 with a completed younger entry -> only the halt entry retires that cycle (retire_en = 2'b01).
